// File: rtl/deck_shuffler.sv
// deck_shuffler: builds a 52-card deck and applies an LFSR-driven
// Fisher-Yates shuffle, then serves registered reads of the shuffled deck.
//   clk        : clock, all state changes on rising edge
//   reset      : synchronous, active-high
//   mix_cards  : shuffle request, rising edge acts (ignored while busy)
//   card_ctrl  : deck position to read, 0..51
//   card       : blackjack value of deck[card_ctrl] (0 when not readable)
//   card_id    : raw id (suit*13 + rank) of deck[card_ctrl] (0 when not readable)
//   shuffle_ok : deck shuffled and readable
//   busy       : high while building or shuffling
module deck_shuffler #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mix_cards,
   input  logic [5:0] card_ctrl,
   output logic [7:0] card,
   output logic [5:0] card_id,
   output logic       shuffle_ok,
   output logic       busy
);

   localparam int unsigned DECK_N    = 52;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [5:0]  LAST_IDX  = 6'(DECK_N - 1);

   typedef enum logic [1:0] {IDLE, INIT, SHUF, DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  idx, idx_nxt;
   logic [15:0] lfsr;
   logic        mix_q;
   logic        start_c;
   logic [5:0]  j_c;
   logic        init_we_c;
   logic        swap_we_c;
   logic        rd_en_c;
   logic [5:0]  rd_id_c;
   logic [5:0]  rank_c;
   logic [7:0]  rd_val_c;

   logic [5:0]  deck [DECK_N];

   assign start_c = mix_cards & ~mix_q;
   assign j_c     = lfsr[5:0];

   // Next-state logic: INIT fills deck[i]=i, SHUF walks i down accepting j<=i.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      init_we_c = 1'b0;
      swap_we_c = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start_c) begin
               state_nxt = INIT;
               idx_nxt   = '0;
            end
         end
         INIT: begin
            init_we_c = 1'b1;
            if (idx == LAST_IDX) state_nxt = SHUF;
            else                 idx_nxt   = idx + 6'd1;
         end
         SHUF: begin
            // Rejected candidates simply wait for the next LFSR value.
            if (j_c <= idx) begin
               swap_we_c = 1'b1;
               idx_nxt   = idx - 6'd1;
               if (idx == 6'd1) state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read path: value derived from rank = id mod 13.
   assign rd_en_c = (state == DONE) && !start_c && (card_ctrl < 6'(DECK_N));
   assign rd_id_c = deck[card_ctrl];

   always_comb begin
      rank_c   = rd_id_c;
      rd_val_c = 8'd10;
      if      (rd_id_c >= 6'd39) rank_c = rd_id_c - 6'd39;
      else if (rd_id_c >= 6'd26) rank_c = rd_id_c - 6'd26;
      else if (rd_id_c >= 6'd13) rank_c = rd_id_c - 6'd13;
      if      (rank_c == 6'd0) rd_val_c = 8'd11;
      else if (rank_c <= 6'd9) rd_val_c = 8'(rank_c) + 8'd1;
   end

   // State, LFSR and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         mix_q      <= 1'b0;
         lfsr       <= SEED_EFF;
         shuffle_ok <= 1'b0;
         busy       <= 1'b0;
         card       <= '0;
         card_id    <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         mix_q      <= mix_cards;
         lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
         shuffle_ok <= (state_nxt == DONE);
         busy       <= (state_nxt == INIT) || (state_nxt == SHUF);
         card       <= rd_en_c ? rd_val_c : 8'd0;
         card_id    <= rd_en_c ? rd_id_c  : 6'd0;
      end
   end

   // Deck storage has no reset; INIT always rebuilds it before shuffling.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (init_we_c) begin
            deck[idx] <= idx;
         end else if (swap_we_c) begin
            deck[idx] <= deck[j_c];
            deck[j_c] <= deck[idx];
         end
      end
   end

endmodule

// File: tb/tb_deck_shuffler.sv
// Scoreboard bench for deck_shuffler: two instances (default seed and seed 0)
// driven in lockstep; expected status/read values queued per instance and
// checked by a negedge monitor.
module tb_deck_shuffler;

   logic       clk = 1'b0;
   logic       reset;
   logic       mix_cards;
   logic [5:0] card_ctrl;
   logic [7:0] card_a, card_z;
   logic [5:0] id_a, id_z;
   logic       ok_a, ok_z, busy_a, busy_z;

   always #5 clk = ~clk;

   deck_shuffler dut_a (
      .clk(clk), .reset(reset), .mix_cards(mix_cards), .card_ctrl(card_ctrl),
      .card(card_a), .card_id(id_a), .shuffle_ok(ok_a), .busy(busy_a)
   );

   deck_shuffler #(.SEED(16'h0000)) dut_z (
      .clk(clk), .reset(reset), .mix_cards(mix_cards), .card_ctrl(card_ctrl),
      .card(card_z), .card_id(id_z), .shuffle_ok(ok_z), .busy(busy_z)
   );

   typedef struct {
      int         due;
      int         tag;
      logic       ok;
      logic       busy;
      logic [7:0] card;
      logic [5:0] id;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int since_rst = 0;
   logic [15:0] seed_of [2];
   int perm [2][52];
   int fin [2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic logic [7:0] val_of(input int id);
      int r;
      r = id % 13;
      if (r == 0) return 8'd11;
      if (r <= 9) return 8'(r + 1);
      return 8'd10;
   endfunction

   function automatic string tag_name(input int t);
      if (t == 0) return "reset";
      if (t == 1) return "shuffle_status";
      return "read";
   endfunction

   // Model: identity deck, then Fisher-Yates with i from 51 down, candidate
   // j = low 6 bits of the LFSR value current at each SHUF edge.
   task automatic predict(input int k, input int m0);
      int d[52];
      logic [15:0] l;
      int i, e, t, jj;
      for (int n = 0; n < 52; n++) d[n] = n;
      l = seed_of[k];
      e = m0 + 53;
      for (int n = 0; n < e - 1; n++) l = lstep(l);
      i = 51;
      fin[k] = -1;
      for (int g = 0; g < 20000; g++) begin
         jj = int'(l[5:0]);
         if (jj <= i) begin
            t = d[i]; d[i] = d[jj]; d[jj] = t;
            if (i == 1) begin
               fin[k] = e;
               break;
            end
            i--;
         end
         l = lstep(l);
         e++;
      end
      for (int n = 0; n < 52; n++) perm[k][n] = d[n];
   endtask

   task automatic push(input int k, input int due, input int tag, input logic ok,
                       input logic bsy, input logic [7:0] c, input logic [5:0] id);
      exp_t x;
      x.due = due; x.tag = tag; x.ok = ok; x.busy = bsy; x.card = c; x.id = id;
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) since_rst = 0;
      else       since_rst++;
      #1;
   endtask

   task automatic reset_seq();
      mix_cards = 1'b0;
      card_ctrl = 6'd0;
      reset = 1'b1;
      repeat (2) begin
         for (int k = 0; k < 2; k++) push(k, cyc + 1, 0, 1'b0, 1'b0, 8'd0, 6'd0);
         tick();
      end
      reset = 1'b0;
      for (int k = 0; k < 2; k++) push(k, cyc + 1, 0, 1'b0, 1'b0, 8'd0, 6'd0);
      tick();
   endtask

   // Raise mix_cards (must be low beforehand) and hold it high throughout.
   task automatic do_shuffle(input int max_cyc);
      int m0, e;
      logic ok;
      card_ctrl = 6'd52;
      mix_cards = 1'b1;
      m0 = since_rst + 1;
      predict(0, m0);
      predict(1, m0);
      for (int k = 0; k < 2; k++) begin
         if (fin[k] < 0) begin
            errors++;
            checks++;
            $display("FAIL model_bound inst=%0d got=no_finish need=finish", k);
         end
      end
      for (int n = 0; n < max_cyc; n++) begin
         e = since_rst + 1;
         for (int k = 0; k < 2; k++) begin
            ok = (fin[k] >= 0) && (e >= fin[k]);
            push(k, cyc + 1, 1, ok, !ok, 8'd0, 6'd0);
         end
         tick();
         if (since_rst >= fin[0] && since_rst >= fin[1]) break;
      end
   endtask

   task automatic rd(input int c);
      int id;
      card_ctrl = 6'(c);
      for (int k = 0; k < 2; k++) begin
         id = (c < 52) ? perm[k][c] : 0;
         push(k, cyc + 1, 2, 1'b1, 1'b0, (c < 52) ? val_of(id) : 8'd0, 6'(id));
      end
      tick();
   endtask

   task automatic sweep();
      for (int c = 0; c < 52; c++) rd(c);
      rd(52);
      rd(63);
      repeat (12) rd(int'($urandom_range(0, 63)));
      rd(5); rd(5); rd(6); rd(6);
   endtask

   task automatic mon(input int k);
      exp_t x;
      logic       a_ok, a_busy;
      logic [7:0] a_card;
      logic [5:0] a_id;
      a_ok   = (k == 0) ? ok_a   : ok_z;
      a_busy = (k == 0) ? busy_a : busy_z;
      a_card = (k == 0) ? card_a : card_z;
      a_id   = (k == 0) ? id_a   : id_z;
      forever begin
         if (k == 0) begin
            if (q0.size() == 0 || q0[0].due > cyc) break;
            x = q0.pop_front();
         end else begin
            if (q1.size() == 0 || q1[0].due > cyc) break;
            x = q1.pop_front();
         end
         checks++;
         if (x.due != cyc || a_ok !== x.ok || a_busy !== x.busy ||
             a_card !== x.card || a_id !== x.id) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d due=%0d got ok=%b busy=%b card=%0d id=%0d need ok=%b busy=%b card=%0d id=%0d ctrl=%0d",
                     tag_name(x.tag), k, cyc, x.due, a_ok, a_busy, a_card, a_id,
                     x.ok, x.busy, x.card, x.id, card_ctrl);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog got=timeout need=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      seed_of[0] = 16'hACE1;
      seed_of[1] = 16'h0001;
      reset = 1'b1;
      mix_cards = 1'b0;
      card_ctrl = 6'd0;

      // Reset, shuffle with mix_cards held high from cycle 2, read back.
      reset_seq();
      do_shuffle(5000);
      sweep();

      // Reshuffle from DONE after a random idle gap.
      mix_cards = 1'b0;
      repeat ($urandom_range(1, 20)) rd(int'($urandom_range(0, 63)));
      do_shuffle(5000);
      sweep();

      // Abort mid-shuffle with reset, then repeat the first run's timing.
      mix_cards = 1'b0;
      rd(3);
      do_shuffle(70);
      reset_seq();
      do_shuffle(5000);
      sweep();

      repeat (3) tick();
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain got=%0d/%0d pending need=0", q0.size(), q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/deck_shuffler.md
DECK_SHUFFLER -- requirements
Module: deck_shuffler

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, the LFSR load value after reset; a value of 0 SHALL be replaced by 16'h0001.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port mix_cards, input, 1 bit: shuffle request; only its rising edge acts.
REQ-005 SHALL have port card_ctrl, input, 6 bits: deck position to read, 0..51.
REQ-006 SHALL have port card, output, 8 bits: blackjack value of the card at position card_ctrl.
REQ-007 SHALL have port card_id, output, 6 bits: raw card identifier at position card_ctrl.
REQ-008 SHALL have port shuffle_ok, output, 1 bit: deck shuffled and readable.
REQ-009 SHALL have port busy, output, 1 bit: high while in INIT or SHUF.

Function
REQ-010 SHALL hold the deck in a 52-entry by 6-bit register array; card id = suit*13 + rank, with suit 0..3 and rank 0..12 (rank 0 = Ace, rank 12 = King).
REQ-011 SHALL implement a 16-bit Galois LFSR, polynomial mask 16'hB400, that shifts every cycle not in reset; the candidate index is j = lfsr[5:0].
REQ-012 SHALL implement FSM states IDLE, INIT, SHUF, DONE.
REQ-013 SHALL register mix_cards into mix_q (reset 0); start = mix_cards & ~mix_q.
REQ-014 SHALL, in IDLE or DONE with start = 1, go to INIT next cycle, clear index i to 0, and drop shuffle_ok that same edge.
REQ-015 SHALL, in INIT, write deck[i] = i and increment i once per cycle for 52 cycles; after writing i = 51 it SHALL load i = 51 and go to SHUF.
REQ-016 SHALL, in SHUF, accept j if j <= i: swap deck[i] and deck[j] in one cycle (j == i leaves the deck unchanged) and decrement i; if j > i, it SHALL reject j and leave the deck and i unchanged.
REQ-017 SHALL, on acceptance with i == 1, go to DONE; shuffle_ok SHALL be 1 from the first cycle in DONE.
REQ-018 SHALL ignore mix_cards edges during INIT and SHUF; those edges are not queued.
REQ-019 SHALL, in DONE, register card and card_id from deck[card_ctrl] with 1-cycle latency: the value presented at edge N appears after edge N+1.
REQ-020 SHALL map value from rank: rank 0 -> 11; rank 1..9 -> rank+1; rank 10..12 -> 10.
REQ-021 SHALL drive card = 0 and card_id = 0 when shuffle_ok = 0 or card_ctrl >= 52.
REQ-022 SHALL be deterministic: the same SEED and the same cycle of the mix_cards edge after reset SHALL give the same permutation.
REQ-023 SHALL leave the deck contents untouched in IDLE and DONE.

Reset
REQ-024 SHALL, with reset = 1 at a clock edge, set state = IDLE, i = 0, mix_q = 0, lfsr = SEED (or 1), shuffle_ok = 0, busy = 0, card = 0, card_id = 0.
REQ-025 SHALL let reset mid-INIT or mid-SHUF abort the operation; the deck contents are then don't-care and stay invisible because shuffle_ok = 0.
REQ-026 SHALL not clear the deck array on reset; INIT always rebuilds it before SHUF.

Verification
REQ-027 Reset, then mix_cards held 1 from cycle 2 -> busy = 1 for 52 INIT cycles plus all SHUF cycles; shuffle_ok rises exactly once; mix_cards still high causes no reshuffle.
REQ-028 After shuffle_ok, sweep card_ctrl 0..51 -> card_id values form a permutation of 0..51 with no duplicates; the card multiset is four each of 2..9 and 11, and sixteen 10s.
REQ-029 SHALL ensure card_id 0, 13, 26 and 39 read as card = 11; id 9 reads 10; id 12 reads 10; card_ctrl = 52 or 63 reads card = 0.
REQ-030 Assert reset during SHUF -> next cycle shuffle_ok = 0, busy = 0, card = 0; a new mix_cards edge completes a full, valid shuffle.
REQ-031 Same SEED, same start cycle, run twice -> identical permutation; SEED = 0 behaves identically to SEED = 1.
REQ-032 In DONE, change card_ctrl 5 -> 6 at edge N -> card shows deck[6] after edge N+1, not before; a mix_cards rising edge in DONE drops shuffle_ok on the next cycle.
